// File: rtl/rotation_pkg.sv
// Shared constants for the 16-bit rotate blocks and the rotation finder FSM.
package rotation_pkg;
  localparam int ROT_W  = 16;
  localparam int ROT_AW = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
endpackage

// File: rtl/rot_match_16bit.sv
// Masked compare: hit when every bit selected by mask agrees with pattern.
module rot_match_16bit
  import rotation_pkg::*;
(
  input  logic [ROT_W-1:0] word,
  input  logic [ROT_W-1:0] pattern,
  input  logic [ROT_W-1:0] mask,
  output logic             hit
);
  assign hit = ~|((word ^ pattern) & mask);
endmodule

// File: rtl/rotation_finder_16bit.sv
// Recovers the smallest right-rotation that maps din onto pattern under mask,
// testing one candidate per clock with a rotate-by-one working register.
module rotation_finder_16bit
  import rotation_pkg::*;
#(
  parameter int W  = ROT_W,
  parameter int AW = ROT_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  din,
  input  logic [W-1:0]  pattern,
  input  logic [W-1:0]  mask,
  output logic          ready,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] amt,
  output logic [W-1:0]  dout,
  output logic [1:0]    state
);
  // Handshake: start is taken on a rising edge where ready=1; done pulses for
  // one cycle and found/amt/dout then hold until the next accepted start.
  logic [W-1:0]  work;
  logic [W-1:0]  orig;
  logic [W-1:0]  pat_q;
  logic [W-1:0]  mask_q;
  logic [AW-1:0] k;
  logic          hit;

  rot_match_16bit u_match (
    .word    (work),
    .pattern (pat_q),
    .mask    (mask_q),
    .hit     (hit)
  );

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      work   <= '0;
      orig   <= '0;
      pat_q  <= '0;
      mask_q <= '0;
      k      <= '0;
      found  <= 1'b0;
      amt    <= '0;
      dout   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work   <= din;
            orig   <= din;
            pat_q  <= pattern;
            mask_q <= mask;
            k      <= '0;
            found  <= 1'b0;
            amt    <= '0;
            state  <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (hit) begin
            found <= 1'b1;
            amt   <= k;
            dout  <= work;
            state <= ST_DONE;
          end else if (k == AW'(W - 1)) begin
            // Last candidate failed: report the untouched input word.
            found <= 1'b0;
            amt   <= '0;
            dout  <= orig;
            state <= ST_DONE;
          end else begin
            work  <= {work[0], work[W-1:1]};
            k     <= k + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/rotation_finder_16bit.md
# rotation_finder_16bit

Sequential rotation-recovery engine for 16-bit words: given a word that was rotated by an unknown amount, it searches the 16 candidate right-rotations one per clock. It reports the smallest amount whose result equals a target pattern under a bit mask, together with the de-rotated word. It sits on the receive side of datapaths that rotate words with the team's 16-bit rotate stages, recovering the `amt` that was applied.

## Interface
Parameters:
- `W`, 16 — word width; fixed at 16 for this revision.
- `AW`, 4 — rotation-amount width; log2(W).

Ports:
- `clk` in 1 — the block's only clock; all state changes on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — request a search; accepted only while `ready`=1.
- `din` in 16 — rotated input word; sampled on the edge that accepts `start`.
- `pattern` in 16 — target word; sampled with `din`.
- `mask` in 16 — compare mask, 1 = bit participates; sampled with `din`.
- `ready` out 1 — high in IDLE only.
- `done` out 1 — one-cycle pulse when a search ends.
- `found` out 1 — 1 = a match was found; valid from `done`, held until the next accepted `start`.
- `amt` out 4 — rotate-right amount k that produced the match; 0 if none.
- `dout` out 16 — rotr(din, k) on a match; the latched `din` if no match.

## Operation
- Compare rule: match when ((rotr(din,k) ^ pattern) & mask) == 0. rotr(x,k) = {x[k-1:0], x[15:k]}, with rotr(x,0) = x.
- FSM states:
  - IDLE: `ready`=1. On `start`=1, latch `din`/`pattern`/`mask` into working registers, clear k to 0, clear `found`/`amt`, and go to SEARCH.
  - SEARCH: the working word holds rotr(din,k).
    - If it matches: register `found`=1, `amt`=k, `dout`=working word, and go to DONE.
    - Else if k=15: register `found`=0, `amt`=0, `dout`=latched din, and go to DONE.
    - Else: rotate the working word right by 1, k←k+1, stay in SEARCH.
  - DONE: `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- Several k values may match; the smallest k wins, because candidates are visited in ascending order.
- `mask`=0 matches at k=0.
- `start` in SEARCH or DONE is ignored; no queuing.
- `found`/`amt`/`dout` are registered and stable from the `done` cycle until the edge that accepts the next `start`.
- k is a 4-bit counter. It never wraps in SEARCH; termination at k=15 is explicit.

## Timing
- Reset (asynchronous, any state): state=IDLE, `ready`=1, `done`=0, `found`=0, `amt`=0, `dout`=0, working registers 0.
- Let E0 be the edge that accepts `start`. A match at candidate k raises `done` during the cycle after edge E(k+1).
  - Best-case latency: 1 cycle after E0.
  - Worst case, including no match: `done` after E16.
- `ready` falls after E0 and rises the cycle after the `done` cycle. Minimum start-to-start spacing is k+3 edges.
- Reset asserted mid-SEARCH aborts the search: no `done` pulse, and outputs take their reset values immediately.
- Inputs need not be held after E0.

## Structure
- Shared package/include `rotation_pkg`:
  - state encodings `ST_IDLE`=2'd0, `ST_SEARCH`=2'd1, `ST_DONE`=2'd2;
  - constants `ROT_W`=16 and `ROT_AW`=4.
  - The team's rotate blocks use the same constants.
- No sub-module is needed: the working word is a rotate-by-one register, so no full barrel shifter is instantiated.
- The optional combinational helper `rot_match_16bit` (masked compare) may be split out for reuse.

## Test plan
- Reset, then `din`=16'h2341, `pattern`=16'h1234, `mask`=16'hFFFF, `start` → `done` after E5, `found`=1, `amt`=4, `dout`=16'h1234.
- `din`=16'h0001, `pattern`=16'h0003, `mask`=16'hFFFF → `done` after E16, `found`=0, `amt`=0, `dout`=16'h0001.
- `din`=16'hAAAA, `pattern`=16'h5555, `mask`=16'hFFFF → `amt`=1 (smallest of k=1,3,…). With `pattern`=16'hAAAA → `amt`=0, `done` after E1.
- `mask`=16'h0000 with arbitrary `din`/`pattern` → `found`=1, `amt`=0. `mask`=16'h000F, `din`=16'h8000, `pattern`=16'h0001 → `amt`=15.
- Pulse `start` again with different data during SEARCH and during DONE → ignored; the first search's results are unchanged and there is exactly one `done` pulse.
- Assert `reset_n`=0 at k=7 of a search → outputs and `ready` take their reset values immediately and no `done` follows. A new `start` after release completes normally.
